// File: rtl/booth_mpy_pkg.sv
// Shared definitions for the Booth multiplier family: FSM state encoding and width helpers.
// Latency: none (package only).
// Backpressure: not applicable.
package booth_mpy_pkg;

    // Two-state controller. Completion is a one-cycle flag, not a state.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Internal Booth width: one guard bit above the operand.
    // The guard bit lets unsigned operands be treated as non-negative signed values.
    function automatic int booth_n(input int width);
        return width + 1;
    endfunction

    // The iteration counter must hold the value N = WIDTH+1.
    function automatic int booth_cnt_w(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/booth_mpy_seq_step.sv
// One radix-2 Booth iteration: add or subtract M according to {Q[0],q_1}, then arithmetic shift right of {A,Q,q_1}.
// Latency: combinational.
// Backpressure: not applicable.
module booth_step #(
    parameter int N = 9
) (
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] q_in,
    input  logic         q1_in,
    input  logic [N-1:0] m_in,
    output logic [N-1:0] a_out,
    output logic [N-1:0] q_out,
    output logic         q1_out
);

    logic [N-1:0] sum;

    // Recode the current multiplier bit pair, then shift with the sign of A replicated.
    always_comb begin
        sum = a_in;
        case ({q_in[0], q1_in})
            2'b01:   sum = a_in + m_in;
            2'b10:   sum = a_in - m_in;
            default: sum = a_in;
        endcase
        a_out  = {sum[N-1], sum[N-1:1]};
        q_out  = {sum[0], q_in[N-1:1]};
        q1_out = q_in[0];
    end

endmodule

// File: rtl/booth_mpy_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned per operation, with a start/busy/done handshake.
// Latency: WIDTH+1 cycles from the accepted start edge to done; product is held until the next completion.
// Backpressure: start is ignored while busy; the done pulse is not stalled.
module booth_mpy_seq
    import booth_mpy_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int N  = booth_n(WIDTH);
    localparam int CW = booth_cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    state_t               state_q, state_d;
    logic [N-1:0]         m_q, m_d;
    logic [N-1:0]         a_q, a_d;
    logic [N-1:0]         q_q, q_d;
    logic                 q1_q, q1_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 done_q, done_d;

    logic [N-1:0]         a_nx;
    logic [N-1:0]         q_nx;
    logic                 q1_nx;
    logic [2*WIDTH-1:0]   prod_nx;

    booth_step #(
        .N (N)
    ) u_step (
        .a_in   (a_q),
        .q_in   (q_q),
        .q1_in  (q1_q),
        .m_in   (m_q),
        .a_out  (a_nx),
        .q_out  (q_nx),
        .q1_out (q1_nx)
    );

    // The 2N-bit {A,Q} is exact for N-bit operands; its low 2*WIDTH bits are the result in both modes.
    assign prod_nx = {a_nx[N-3:0], q_nx};

    // Next-state and datapath control: load operands in IDLE, iterate in RUN, publish on the last iteration.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        a_d       = a_q;
        q_d       = q_q;
        q1_d      = q1_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d     = {signed_mode & a[WIDTH-1], a};
                    a_d     = '0;
                    q_d     = {signed_mode & b[WIDTH-1], b};
                    q1_d    = 1'b0;
                    cnt_d   = CNT_LOAD;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d   = a_nx;
                q_d   = q_nx;
                q1_d  = q1_nx;
                cnt_d = cnt_q - CNT_LAST;
                if (cnt_q == CNT_LAST) begin
                    product_d = prod_nx;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight without a done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            a_q       <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            a_q       <= a_d;
            q_q       <= q_d;
            q1_q      <= q1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q == S_RUN);
    assign done    = done_q;
    assign product = product_q;

endmodule
